// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder: FSM state encoding and
// the bit-counter width calculation.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Counter must index bits 0..width-1; a 1-bit operand still needs a 1-bit counter.
  function automatic int cnt_w(input int width);
    return (width <= 1) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_adder_bit_add_cell.sv
// One-bit full adder built from two half-adder stages and an OR that merges
// their carries. Purely combinational.
module bit_add_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);

  logic hs1;
  logic hc1;
  logic hc2;

  assign hs1 = a_i ^ b_i;
  assign hc1 = a_i & b_i;
  assign s_o = hs1 ^ c_i;
  assign hc2 = hs1 & c_i;
  assign c_o = hc1 | hc2;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: accepts WIDTH-bit operands, adds LSB-first one bit per clock
// through bit_add_cell, then presents sum/cout. Define SERIAL_ADDER_SUB_EN for a sub port.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int            CW   = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             cell_s;
  logic             cell_c;
  logic [WIDTH:0]   res_ext;
  logic [WIDTH-1:0] b_load;
  logic             cin_load;

`ifdef SERIAL_ADDER_SUB_EN
  // Subtract as a + ~b + 1: invert b on load and seed the carry with 1.
  assign b_load   = sub ? ~b : b;
  assign cin_load = sub;
`else
  assign b_load   = b;
  assign cin_load = 1'b0;
`endif

  bit_add_cell u_cell (
    .a_i (a_sh_q[0]),
    .b_i (b_sh_q[0]),
    .c_i (carry_q),
    .s_o (cell_s),
    .c_o (cell_c)
  );

  // Widened concat keeps the shift-in legal even when WIDTH is 1.
  assign res_ext = {cell_s, result_q};

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    result_d = result_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_sh_d  = a;
          b_sh_d  = b_load;
          carry_d = cin_load;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        result_d = res_ext[WIDTH:1];
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        carry_d  = cell_c;
        if (cnt_q == LAST) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = result_q;
  assign cout      = carry_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8) with a result scoreboard.
// Define SERIAL_ADDER_SUB_EN to also exercise the subtract mode.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         sub_r;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W:0] exp_q[$];

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef SERIAL_ADDER_SUB_EN
    .sub       (sub_r),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
  );

  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    if (s) return {1'b0, x} + {1'b0, ~y} + (W+1)'(1);
    return {1'b0, x} + {1'b0, y};
  endfunction

  // Present operands until accepted; returns at acceptance edge + 1ns.
  task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv, output bit ok);
    bit acc;
    ok = 1'b0;
    a = av; b = bv; sub_r = sv; in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      if (acc) begin
        ok = 1'b1;
        exp_q.push_back(model(av, bv, sv));
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  // Count edges from acceptance until out_valid is seen.
  task automatic wait_out(output int cycles, output bit to);
    to = 1'b1;
    cycles = 0;
    for (int i = 1; i <= 64; i++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        cycles = i;
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; sub_r = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_checks++; if (sum !== 8'h00) begin n_fail++; $display("FAIL reset_sum got %h want 00", sum); end
    n_checks++; if (cout !== 1'b0) begin n_fail++; $display("FAIL reset_cout got %b want 0", cout); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // One add with out_ready high: checks latency, result and return to IDLE.
  task automatic test_add(input string nm, input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv,
                          input logic [W-1:0] esum, input logic ecout);
    bit ok, to; int cyc; logic [W:0] e;
    out_ready = 1'b1;
    send(av, bv, sv, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL %s_accept got timeout want accept", nm); return; end
    wait_out(cyc, to);
    n_checks++; if (to || cyc != W) begin n_fail++; $display("FAIL %s_latency got %0d want %0d", nm, cyc, W); end
    if (to) begin exp_q.delete(); return; end
    e = exp_q.pop_front();
    n_checks++; if ({cout, sum} !== e) begin n_fail++; $display("FAIL %s_model got %b_%h want %b_%h", nm, cout, sum, e[W], e[W-1:0]); end
    n_checks++; if (sum !== esum) begin n_fail++; $display("FAIL %s_sum got %h want %h", nm, sum, esum); end
    n_checks++; if (cout !== ecout) begin n_fail++; $display("FAIL %s_cout got %b want %b", nm, cout, ecout); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL %s_done_in_ready got %b want 0", nm, in_ready); end
    @(posedge clk); #1;
    n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL %s_idle got in_ready=%b out_valid=%b want 1/0", nm, in_ready, out_valid);
    end
  endtask

  task automatic test_backpressure();
    bit ok, to; int cyc; logic [W:0] e; logic [W-1:0] s0; logic c0;
    out_ready = 1'b0;
    send(8'hC3, 8'h7E, 1'b0, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL bp_accept got timeout want accept"); return; end
    wait_out(cyc, to);
    n_checks++; if (to) begin n_fail++; $display("FAIL bp_out_valid got timeout want valid"); exp_q.delete(); return; end
    e = exp_q.pop_front();
    s0 = sum; c0 = cout;
    n_checks++; if ({c0, s0} !== e) begin n_fail++; $display("FAIL bp_result got %b_%h want %b_%h", c0, s0, e[W], e[W-1:0]); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (out_valid !== 1'b1 || sum !== s0 || cout !== c0 || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold%0d got v=%b s=%h c=%b r=%b want v=1 s=%h c=%b r=0", i, out_valid, sum, cout, in_ready, s0, c0);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_consume got v=%b r=%b want v=0 r=1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    out_ready = 1'b1;
    send(8'hAB, 8'hCD, 1'b0, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL rstmid_accept got timeout want accept"); end
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q.delete();
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== 8'h00 || cout !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_state got r=%b v=%b s=%h c=%b want r=1 v=0 s=00 c=0", in_ready, out_valid, sum, cout);
    end
    @(posedge clk); #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_no_result got %b want 0", out_valid); end
    test_add("post_rst", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0);
  endtask

  task automatic test_back_to_back();
    int acc = 0;
    int got = 0;
    logic [W:0] e;
    exp_q.delete();
    out_ready = 1'b1; sub_r = 1'b0;
    a = W'($urandom); b = W'($urandom); in_valid = 1'b1;
    for (int cyc = 0; cyc < 200 && got < 4; cyc++) begin
      @(negedge clk);
      if (out_valid) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL b2b_extra got %b_%h want no result", cout, sum);
        end else begin
          e = exp_q.pop_front();
          if ({cout, sum} !== e || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_res%0d got %b_%h r=%b want %b_%h r=0", got, cout, sum, in_ready, e[W], e[W-1:0]);
          end
        end
        got++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(a, b, 1'b0));
        acc++;
      end
      @(posedge clk); #1;
      if (acc >= 4) in_valid = 1'b0;
      else begin a = W'($urandom); b = W'($urandom); end
    end
    n_checks++; if (got != 4 || exp_q.size() != 0) begin
      n_fail++; $display("FAIL b2b_count got %0d results (%0d pending) want 4 (0)", got, exp_q.size());
    end
    in_valid = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_add("basic", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0);
    test_add("ovf", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    test_add("zero", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
`ifdef SERIAL_ADDER_SUB_EN
    test_add("sub_nb", 8'h10, 8'h01, 1'b1, 8'h0F, 1'b1);
    test_add("sub_b", 8'h01, 8'h02, 1'b1, 8'hFF, 1'b0);
    test_add("sub_off", 8'h10, 8'h01, 1'b0, 8'h11, 1'b0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial ripple adder: accepts two WIDTH-bit operands over a valid/ready handshake.
- Adds them LSB-first, one bit per clock, through a single full-adder cell built from two half-adder stages plus an OR.
- Presents the WIDTH-bit sum and carry-out over a second valid/ready handshake.
- Sits directly downstream of the half-adder cell: it is the sequential consumer that chains the cell's sum/carry over time. It trades area for latency in the combinational arithmetic library.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 1..64.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  operands a/b valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- out_valid  output  1  sum/cout valid.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  a+b modulo 2^WIDTH.
- cout  output  1  carry out of bit WIDTH-1.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-low, rst_n. All state updates on the rising edge of clk.
- Reset (rst_n=0 at a rising edge):
  - state=IDLE.
  - in_ready=1, out_valid=0, sum=0, cout=0.
  - Internal shift registers, carry flop and bit counter all cleared.
- Reset mid-operation aborts the calculation; the partial result is discarded and never presented.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid & in_ready: load a and b into shift registers, carry<=0, count<=0, go to RUN.
- RUN:
  - in_ready=0, out_valid=0.
  - Each cycle, the cell computes s,c from a_sh[0], b_sh[0] and carry.
  - result <= {s, result[WIDTH-1:1]}; a_sh and b_sh shift right by one; carry<=c; count<=count+1.
  - When count==WIDTH-1, go to DONE.
- DONE:
  - out_valid=1; sum=result; cout=carry. Both held stable while out_valid & !out_ready.
  - On out_ready: go to IDLE.
  - in_ready=0 in DONE, so a new operand is not accepted in the same cycle a result is consumed.
- Latency: the acceptance edge is T0; out_valid is first high after edge T0+WIDTH. Throughput is one add per WIDTH+2 cycles when out_ready is held high.
- Width rules:
  - Counter width is max(1, $clog2(WIDTH)); no wrap past WIDTH-1.
  - WIDTH=1: RUN lasts exactly one cycle.
- Overflow is not a fault: sum wraps modulo 2^WIDTH, and the carry appears on cout.
- a and b are sampled only at the acceptance edge; later changes on them are ignored.

Optional Feature:
- Macro: SERIAL_ADDER_SUB_EN.
- Defined:
  - Extra input port sub (1 bit), sampled at acceptance.
  - sub=1: b is loaded inverted and the carry flop initialises to 1, so sum = a-b mod 2^WIDTH.
  - cout=1 means no borrow.
  - sub=0: identical to plain add.
- Undefined: no sub port; add only; no inverter logic synthesized.

Decomposition:
- Package serial_adder_pkg:
  - state enum typedef (IDLE=2'd0, RUN=2'd1, DONE=2'd2).
  - function cnt_w(WIDTH) returning the counter width.
- Sub-module bit_add_cell:
  - 1-bit full adder made of two half-adder stages (xor/and) plus an OR for carry.
  - Purely combinational; instantiated once.

Test Plan (WIDTH=8):
- Reset, then a=8'h5A, b=8'h3C, in_valid pulse, out_ready=1 -> out_valid high exactly 8 cycles after acceptance, sum=8'h96, cout=0; returns to IDLE with in_ready=1 one cycle later.
- a=8'hFF, b=8'h01 -> sum=8'h00, cout=1. Then a=8'h00, b=8'h00 -> sum=8'h00, cout=0.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> sum/cout/out_valid stable for all 5 cycles, in_ready=0 throughout; the result is consumed on the first out_ready=1 cycle.
- rst_n=0 for one cycle during RUN (count=3) -> next cycle in IDLE, out_valid=0, sum=0, cout=0. A following add of 8'h12+8'h34 gives 8'h46.
- Back-to-back: in_valid held high with a/b changing every cycle -> only the values present at acceptance edges are used. Each result matches its operand pair, and no acceptance occurs while in_ready=0.
- SERIAL_ADDER_SUB_EN defined:
  - sub=1, a=8'h10, b=8'h01 -> sum=8'h0F, cout=1.
  - sub=1, a=8'h01, b=8'h02 -> sum=8'hFF, cout=0.
